// File: rtl/manycore_host_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : manycore_host_mem_responder
// Brief    : Host-side IO-link endpoint; services load/store/AMO requests
//            against a flop memory and returns one response per request.
// Revision : 1.0
// ============================================================================
module manycore_host_mem_responder #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int reg_id_width_p = 5,
  parameter int els_p          = 1024,
  parameter logic [addr_width_p-1:0] stat_addr_p = 28'h0FF_FFFF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        req_v_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_op_i,
  input  logic [addr_width_p-1:0]     req_addr_i,
  input  logic [data_width_p-1:0]     req_data_i,
  input  logic [data_width_p/8-1:0]   req_mask_i,
  input  logic [x_cord_width_p-1:0]   req_src_x_i,
  input  logic [y_cord_width_p-1:0]   req_src_y_i,
  input  logic [reg_id_width_p-1:0]   req_reg_id_i,
  output logic                        resp_v_o,
  input  logic                        resp_ready_i,
  output logic [1:0]                  resp_type_o,
  output logic [data_width_p-1:0]     resp_data_o,
  output logic [x_cord_width_p-1:0]   resp_dst_x_o,
  output logic [y_cord_width_p-1:0]   resp_dst_y_o,
  output logic [reg_id_width_p-1:0]   resp_reg_id_o,
  output logic                        print_stat_v_o,
  output logic [data_width_p-1:0]     print_stat_tag_o,
  output logic                        err_o
);

  localparam int c_idx_w = $clog2(els_p);
  localparam logic [addr_width_p:0] c_els = (addr_width_p+1)'(els_p);

  localparam logic [1:0] c_op_load    = 2'd0;
  localparam logic [1:0] c_op_store   = 2'd1;
  localparam logic [1:0] c_op_amoadd  = 2'd2;

  localparam logic [1:0] c_type_load  = 2'd0;
  localparam logic [1:0] c_type_store = 2'd1;
  localparam logic [1:0] c_type_amo   = 2'd2;

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                      r_state, w_state_next;
  logic [data_width_p-1:0]     r_mem [els_p];
  logic [1:0]                  r_resp_type;
  logic [data_width_p-1:0]     r_resp_data;
  logic [x_cord_width_p-1:0]   r_resp_dst_x;
  logic [y_cord_width_p-1:0]   r_resp_dst_y;
  logic [reg_id_width_p-1:0]   r_resp_reg_id;
  logic                        r_print_v;
  logic [data_width_p-1:0]     r_print_tag;
  logic                        r_err;

  logic [c_idx_w-1:0]          w_idx;
  logic                        w_accept;
  logic                        w_is_stat;
  logic                        w_in_range;
  logic [data_width_p-1:0]     w_old;
  logic [data_width_p-1:0]     w_wdata;
  logic                        w_we;
  logic [1:0]                  w_resp_type;
  logic [data_width_p-1:0]     w_resp_data;
  logic                        w_err_set;
  logic                        w_stat_store;

  assign resp_v_o         = (r_state == FULL);
  assign req_ready_o      = ~resp_v_o | resp_ready_i;
  assign w_accept         = req_v_i & req_ready_o;
  assign w_idx            = req_addr_i[c_idx_w-1:0];
  assign w_is_stat        = (req_addr_i == stat_addr_p);
  assign w_in_range       = ({1'b0, req_addr_i} < c_els);
  assign w_old            = r_mem[w_idx];

  assign resp_type_o      = r_resp_type;
  assign resp_data_o      = r_resp_data;
  assign resp_dst_x_o     = r_resp_dst_x;
  assign resp_dst_y_o     = r_resp_dst_y;
  assign resp_reg_id_o    = r_resp_reg_id;
  assign print_stat_v_o   = r_print_v;
  assign print_stat_tag_o = r_print_tag;
  assign err_o            = r_err;

  // Operation decode; the stat address and out-of-range addresses never write memory
  always_comb begin
    w_wdata      = w_old;
    w_we         = 1'b0;
    w_resp_type  = c_type_amo;
    w_resp_data  = '0;
    w_err_set    = 1'b0;
    w_stat_store = 1'b0;
    case (req_op_i)
      c_op_load:  w_resp_type = c_type_load;
      c_op_store: begin
        w_resp_type = c_type_store;
        for (int b = 0; b < data_width_p/8; b++) begin
          if (req_mask_i[b]) w_wdata[8*b +: 8] = req_data_i[8*b +: 8];
        end
      end
      c_op_amoadd: w_wdata = w_old + req_data_i;
      default:     w_wdata = req_data_i;
    endcase
    if (w_is_stat) begin
      w_stat_store = w_accept & (req_op_i == c_op_store);
    end else if (!w_in_range) begin
      w_err_set = w_accept;
    end else begin
      w_we = w_accept & (req_op_i != c_op_load);
      if (req_op_i != c_op_store) w_resp_data = w_old;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept)          w_state_next = FULL;
    else if (resp_ready_i) w_state_next = EMPTY;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= EMPTY;
      r_resp_type   <= '0;
      r_resp_data   <= '0;
      r_resp_dst_x  <= '0;
      r_resp_dst_y  <= '0;
      r_resp_reg_id <= '0;
      r_print_v     <= 1'b0;
      r_print_tag   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_print_v <= w_stat_store;
      if (w_accept) begin
        r_resp_type   <= w_resp_type;
        r_resp_data   <= w_resp_data;
        r_resp_dst_x  <= req_src_x_i;
        r_resp_dst_y  <= req_src_y_i;
        r_resp_reg_id <= req_reg_id_i;
      end
      if (w_stat_store) r_print_tag <= req_data_i;
      if (w_err_set)    r_err       <= 1'b1;
    end
  end

  // Memory is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[w_idx] <= w_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_manycore_host_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_manycore_host_mem_responder
// Brief    : Self-checking bench: directed vectors, backpressure sequences and
//            randomized traffic against a behavioural memory model.
// Revision : 1.0
// ============================================================================
module tb_manycore_host_mem_responder;

  localparam logic [27:0] c_stat = 28'h0FF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_v = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_mask = '0;
  logic [6:0]  req_x = '0;
  logic [6:0]  req_y = '0;
  logic [4:0]  req_id = '0;
  logic        resp_v;
  logic        resp_ready = 1'b1;
  logic [1:0]  resp_type;
  logic [31:0] resp_data;
  logic [6:0]  resp_x;
  logic [6:0]  resp_y;
  logic [4:0]  resp_id;
  logic        pst_v;
  logic [31:0] pst_tag;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [1024];
  bit          err_m = 1'b0;
  logic [31:0] tag_m = '0;

  always #5 clk = ~clk;

  manycore_host_mem_responder dut (
    .clk_i(clk), .reset_i(rst),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
    .req_src_x_i(req_x), .req_src_y_i(req_y), .req_reg_id_i(req_id),
    .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_type_o(resp_type),
    .resp_data_o(resp_data), .resp_dst_x_o(resp_x), .resp_dst_y_o(resp_y),
    .resp_reg_id_o(resp_id), .print_stat_v_o(pst_v), .print_stat_tag_o(pst_tag),
    .err_o(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural view of one request: what it returns and how it changes state
  task automatic model(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] d,
                       input logic [3:0] m, output logic [1:0] t, output logic [31:0] rd,
                       output bit pulse);
    logic [31:0] old;
    t     = (op == 2'd0) ? 2'd0 : (op == 2'd1) ? 2'd1 : 2'd2;
    rd    = '0;
    pulse = 1'b0;
    if (addr == c_stat) begin
      if (op == 2'd1) begin pulse = 1'b1; tag_m = d; end
    end else if (addr >= 28'd1024) begin
      err_m = 1'b1;
    end else begin
      old = mem_m[addr[9:0]];
      case (op)
        2'd0: rd = old;
        2'd1: for (int b = 0; b < 4; b++)
                if (m[b]) mem_m[addr[9:0]][8*b +: 8] = d[8*b +: 8];
        2'd2: begin rd = old; mem_m[addr[9:0]] = old + d; end
        default: begin rd = old; mem_m[addr[9:0]] = d; end
      endcase
    end
  endtask

  // One isolated transaction with `stall` cycles of response backpressure
  task automatic run_txn(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] d,
                         input logic [3:0] m, input logic [1:0] et, input logic [31:0] ed,
                         input bit ep, input int stall);
    logic [6:0] x, y;
    logic [4:0] id;
    x = 7'($urandom); y = 7'($urandom); id = 5'($urandom);
    req_v = 1'b1; req_op = op; req_addr = addr; req_data = d; req_mask = m;
    req_x = x; req_y = y; req_id = id;
    resp_ready = (stall == 0);
    chk("req_ready_idle", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    req_v = 1'b0;
    chk("resp_v", 32'(resp_v), 32'(1));
    chk("resp_type", 32'(resp_type), 32'(et));
    chk("resp_data", resp_data, ed);
    chk("resp_dst_x", 32'(resp_x), 32'(x));
    chk("resp_dst_y", 32'(resp_y), 32'(y));
    chk("resp_reg_id", 32'(resp_id), 32'(id));
    chk("print_stat_v", 32'(pst_v), 32'(ep));
    chk("print_stat_tag", pst_tag, tag_m);
    chk("err", 32'(err), 32'(err_m));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_resp_v", 32'(resp_v), 32'(1));
      chk("stall_req_ready", 32'(req_ready), 32'(0));
      chk("stall_resp_data", resp_data, ed);
      chk("stall_reg_id", 32'(resp_id), 32'(id));
      chk("stall_pst_pulse", 32'(pst_v), 32'(0));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_drained", 32'(resp_v), 32'(0));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  et;
    logic [31:0] ed;
  } vec_t;

  initial begin
    vec_t        vt [10];
    logic [1:0]  t;
    logic [31:0] rd;
    bit          p;
    logic [27:0] qa [5];
    logic [31:0] qd [5];

    vt[0] = '{2'd1, 28'd5, 32'hDEADBEEF, 4'hF, 2'd1, 32'h0};
    vt[1] = '{2'd0, 28'd5, 32'h0,        4'h0, 2'd0, 32'hDEADBEEF};
    vt[2] = '{2'd1, 28'd6, 32'h11223344, 4'hF, 2'd1, 32'h0};
    vt[3] = '{2'd1, 28'd6, 32'hAABBCCDD, 4'h5, 2'd1, 32'h0};
    vt[4] = '{2'd0, 28'd6, 32'h0,        4'h0, 2'd0, 32'h11BB33DD};
    vt[5] = '{2'd1, 28'd7, 32'h00000001, 4'hF, 2'd1, 32'h0};
    vt[6] = '{2'd2, 28'd7, 32'hFFFFFFFF, 4'h0, 2'd2, 32'h1};
    vt[7] = '{2'd0, 28'd7, 32'h0,        4'h0, 2'd0, 32'h0};
    vt[8] = '{2'd3, 28'd7, 32'h00000007, 4'h0, 2'd2, 32'h0};
    vt[9] = '{2'd0, 28'd7, 32'h0,        4'h0, 2'd0, 32'h7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_v", 32'(resp_v), 32'(0));
    chk("rst_resp_type", 32'(resp_type), 32'(0));
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_dst", 32'({resp_x, resp_y, resp_id}), 32'(0));
    chk("rst_pst", 32'(pst_v), 32'(0));
    chk("rst_tag", pst_tag, 32'h0);
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      model(vt[i].op, vt[i].addr, vt[i].data, vt[i].mask, t, rd, p);
      run_txn(vt[i].op, vt[i].addr, vt[i].data, vt[i].mask, vt[i].et, vt[i].ed, 1'b0, i % 3);
    end

    // Backpressure with a waiting request, then four back-to-back responses
    qa = '{28'd5, 28'd6, 28'd7, 28'd5, 28'd6};
    qd = '{32'hDEADBEEF, 32'h11BB33DD, 32'h7, 32'hDEADBEEF, 32'h11BB33DD};
    resp_ready = 1'b0;
    req_v = 1'b1; req_op = 2'd0; req_addr = qa[0]; req_id = 5'd0;
    @(posedge clk); #1;
    req_addr = qa[1]; req_id = 5'd1;
    for (int s = 0; s < 3; s++) begin
      chk("bp_req_ready", 32'(req_ready), 32'(0));
      chk("bp_resp_v", 32'(resp_v), 32'(1));
      chk("bp_resp_data", resp_data, qd[0]);
      chk("bp_reg_id", 32'(resp_id), 32'(0));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'(1));
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stream_resp_v", 32'(resp_v), 32'(1));
      chk("stream_data", resp_data, qd[k]);
      chk("stream_reg_id", 32'(resp_id), 32'(k));
      if (k < 4) begin req_addr = qa[k+1]; req_id = 5'(k + 1); end
      else req_v = 1'b0;
    end
    @(posedge clk); #1;
    chk("stream_drained", 32'(resp_v), 32'(0));

    // Stat register and out-of-range handling
    model(2'd1, c_stat, 32'h42, 4'h1, t, rd, p);
    run_txn(2'd1, c_stat, 32'h42, 4'h1, 2'd1, 32'h0, 1'b1, 1);
    chk("stat_tag_hold", pst_tag, 32'h42);
    model(2'd0, c_stat, 32'h0, 4'h0, t, rd, p);
    run_txn(2'd0, c_stat, 32'h0, 4'h0, 2'd0, 32'h0, 1'b0, 0);
    model(2'd2, c_stat, 32'h5, 4'h0, t, rd, p);
    run_txn(2'd2, c_stat, 32'h5, 4'h0, 2'd2, 32'h0, 1'b0, 0);
    chk("stat_no_err", 32'(err), 32'(0));
    model(2'd0, 28'd1024, 32'h0, 4'h0, t, rd, p);
    run_txn(2'd0, 28'd1024, 32'h0, 4'h0, 2'd0, 32'h0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 chk("err_sticky", 32'(err), 32'(1));
    model(2'd0, 28'd5, 32'h0, 4'h0, t, rd, p);
    run_txn(2'd0, 28'd5, 32'h0, 4'h0, 2'd0, 32'hDEADBEEF, 1'b0, 0);

    // Randomized traffic against the model
    for (int a = 0; a < 16; a++) begin
      logic [31:0] d;
      d = $urandom;
      model(2'd1, 28'(a), d, 4'hF, t, rd, p);
      run_txn(2'd1, 28'(a), d, 4'hF, t, rd, p, 0);
    end
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [27:0] addr;
      logic [31:0] d;
      logic [3:0]  m;
      int          sel;
      op  = 2'($urandom);
      d   = $urandom;
      m   = 4'($urandom);
      sel = $urandom_range(0, 19);
      if (sel == 0)      addr = c_stat;
      else if (sel == 1) addr = 28'd1024 + 28'($urandom_range(0, 5000));
      else               addr = 28'($urandom_range(0, 15));
      model(op, addr, d, m, t, rd, p);
      run_txn(op, addr, d, m, t, rd, p, $urandom_range(0, 2));
    end

    // Reset while a response is pending
    resp_ready = 1'b0;
    req_v = 1'b1; req_op = 2'd0; req_addr = 28'd3;
    @(posedge clk); #1;
    req_v = 1'b0;
    chk("pre_rst_full", 32'(resp_v), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_resp_v", 32'(resp_v), 32'(0));
    chk("async_rst_err", 32'(err), 32'(0));
    chk("async_rst_tag", pst_tag, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_m = 1'b0; tag_m = '0;
    resp_ready = 1'b1;
    #1 chk("post_rst_req_ready", 32'(req_ready), 32'(1));
    model(2'd0, 28'd5, 32'h0, 4'h0, t, rd, p);
    run_txn(2'd0, 28'd5, 32'h0, 4'h0, t, rd, p, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
